// File: rtl/alu_preproc_pipe.sv
// Registered ALU operand preprocessor: decodes an opcode into adder operands and a carry-in,
// behind a valid/ready handshake with a 2-entry skid buffer and a registered in_ready.
module alu_preproc_pipe #(
  parameter int unsigned W = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic [2:0]   op,
  input  logic         cin_i,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] amod,
  output logic [W-1:0] bmod,
  output logic         cin_o,
  output logic [2:0]   out_op
);

  typedef struct packed {
    logic [W-1:0] amod;
    logic [W-1:0] bmod;
    logic         cin;
    logic [2:0]   op;
  } entry_t;

  entry_t dec;
  entry_t out_q, out_d;
  entry_t skd_q, skd_d;
  logic   out_valid_q, out_valid_d;
  logic   skd_valid_q, skd_valid_d;
  logic   in_ready_q, in_ready_d;
  logic   accept, consume;

  always_comb begin
    dec      = '0;
    dec.op   = op;
    dec.amod = a;
    case (op)
      3'b000: ;
      3'b001: begin
        dec.amod = '0;
        dec.bmod = ~a;
        dec.cin  = 1'b1;
      end
      3'b010: dec.cin = 1'b1;
      3'b011: dec.bmod = '1;
      3'b100: dec.bmod = b;
      3'b101: begin
        dec.bmod = ~b;
        dec.cin  = 1'b1;
      end
      3'b110: begin
        dec.bmod = b;
        dec.cin  = cin_i;
      end
      3'b111: begin
        dec.amod = b;
        dec.bmod = ~a;
        dec.cin  = 1'b1;
      end
      default: ;
    endcase
  end

  assign accept  = in_valid & in_ready_q;
  assign consume = out_valid_q & out_ready;

  // in_ready_q mirrors ~skd_valid_q, so an accept never coincides with a full skid register.
  always_comb begin
    out_d       = out_q;
    skd_d       = skd_q;
    out_valid_d = out_valid_q;
    skd_valid_d = skd_valid_q;
    if (consume) begin
      out_valid_d = 1'b0;
      if (skd_valid_q) begin
        out_d       = skd_q;
        out_valid_d = 1'b1;
        skd_valid_d = 1'b0;
      end
    end
    if (accept) begin
      if (!out_valid_q || consume) begin
        out_d       = dec;
        out_valid_d = 1'b1;
      end else begin
        skd_d       = dec;
        skd_valid_d = 1'b1;
      end
    end
    in_ready_d = ~skd_valid_d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_q       <= '0;
      skd_q       <= '0;
      out_valid_q <= 1'b0;
      skd_valid_q <= 1'b0;
      in_ready_q  <= 1'b1;
    end else begin
      out_q       <= out_d;
      skd_q       <= skd_d;
      out_valid_q <= out_valid_d;
      skd_valid_q <= skd_valid_d;
      in_ready_q  <= in_ready_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign amod      = out_q.amod;
  assign bmod      = out_q.bmod;
  assign cin_o     = out_q.cin;
  assign out_op    = out_q.op;

endmodule

// File: doc/alu_preproc_pipe.md
Name: alu_preproc_pipe

Overview:
- Parametrised, registered operand preprocessor for the ALU datapath.
- Decodes a 3-bit opcode into adder-ready operands AMod, BMod and a carry-in, so one adder executes pass/neg/inc/dec/add/sub/adc/reverse-sub.
- Sits between the operand source and the adder stage.
- valid/ready handshake on both sides; 2-entry skid buffer gives full throughput with a registered in_ready.

Parameters:
- W, 4, operand/result width in bits (W >= 2).

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous reset, active-high
- in_valid  input  1  upstream request carries valid a/b/op/cin_i
- in_ready  output  1  block can accept; registered, no combinational path from out_ready
- a  input  W  operand A
- b  input  W  operand B
- op  input  3  operation select
- cin_i  input  1  external carry, used only by ADC
- out_valid  output  1  amod/bmod/cin_o/out_op valid
- out_ready  input  1  downstream accepts
- amod  output  W  adder operand 1
- bmod  output  W  adder operand 2
- cin_o  output  1  adder carry-in
- out_op  output  3  opcode carried alongside its operands

Behaviour:
- Decode (combinational on inputs, captured at accept):
  - 000 PASS: amod=A, bmod=0, cin=0
  - 001 NEG: amod=0, bmod=~A, cin=1
  - 010 INC: amod=A, bmod=0, cin=1
  - 011 DEC: amod=A, bmod=all-ones, cin=0
  - 100 ADD: amod=A, bmod=B, cin=0
  - 101 SUB: amod=A, bmod=~B, cin=1
  - 110 ADC: amod=A, bmod=B, cin=cin_i
  - 111 RSUB: amod=B, bmod=~A, cin=1
- All operations are exactly W bits; no sign extension. Overflow and carry-out are the adder's concern.
- Accept when in_valid & in_ready. Consume when out_valid & out_ready.
- Storage: output register (OUT) plus skid register (SKD), each with its own valid bit.
- Each cycle:
  - Accept and (OUT empty or OUT consumed) and SKD empty: decoded entry goes to OUT.
  - Accept and OUT full and not consumed: decoded entry goes to SKD.
  - OUT consumed and SKD full: SKD moves to OUT, SKD empties.
  - Accept while SKD is draining cannot occur, because in_ready=0 whenever SKD is full.
- in_ready is registered: in_ready = ~SKD_valid as of the previous clock edge.
- Latency: accepted entry appears on outputs the cycle after accept when OUT is free. Strict FIFO order.
- Throughput: one transfer per cycle sustained when out_ready is held high.
- Stall: with out_ready=0, at most 2 entries are held. in_ready drops the cycle after the second accept. OUT values stay stable while out_valid=1 and out_ready=0.
- Empty: out_valid=0. amod/bmod/cin_o/out_op hold their last values (don't-care).
- Reset (synchronous, rst=1 at a rising edge) clears, at that edge:
  - out_valid=0, OUT and SKD valid bits = 0
  - in_ready=1
  - amod=0, bmod=0, cin_o=0, out_op=0
- Reset mid-stall: in-flight entries are discarded; no transfer completes on the reset edge.
- While rst=1, in_valid is ignored.

Test Plan:
- W=8, out_ready=1, op=101, A=0x05, B=0x03 -> next cycle out_valid=1, amod=0x05, bmod=0xFC, cin_o=1, out_op=101.
- W=8, back-to-back ops 000,001,010,011,110(cin_i=1),111 with A=0x10, B=0x20 -> outputs in order:
  - (10,00,0)
  - (00,EF,1)
  - (10,00,1)
  - (10,FF,0)
  - (10,20,1)
  - (20,EF,1)
  - one per cycle, no bubbles.
- Hold out_ready=0, present 3 consecutive valid ADDs -> first two accepted; in_ready=0 from the cycle after the 2nd accept; third held off; out_valid=1 with the first entry stable.
- From that full state, raise out_ready for 3 cycles -> entries emitted in order 1,2,3; in_ready returns to 1 one cycle after SKD drains.
- With 2 entries buffered, assert rst one cycle -> next cycle out_valid=0, in_ready=1, amod=bmod=0; nothing emitted.
- W=4 boundary: op=011, A=0x0 -> amod=0x0, bmod=0xF, cin_o=0. op=001, A=0x8 -> bmod=0x7, cin_o=1.
